// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler: op codes, FSM encodings and
// the latched layer configuration.
package layer_sched_pkg;
  localparam int unsigned BURST_LEN = 8;

  localparam logic [2:0] OP_CONV  = 3'd1;
  localparam logic [2:0] OP_MPOOL = 3'd2;
  localparam logic [2:0] OP_APOOL = 3'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CFG   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAITF = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  kernel;
    logic [3:0]  stride;
    logic [7:0]  i_side;
    logic [7:0]  o_side;
    logic [15:0] i_channel;
    logic [15:0] o_channel;
  } cfg_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_CONV) || (op == OP_MPOOL) || (op == OP_APOOL);
  endfunction
endpackage

// File: rtl/layer_sched_if.sv
// Command, DMA and engine signals of the layer scheduler.
interface layer_sched_if;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_kernel;
  logic [3:0]  cmd_stride;
  logic [7:0]  cmd_i_side, cmd_o_side;
  logic [15:0] cmd_i_channel, cmd_o_channel;
  logic        fetch_req, fetch_done;
  logic [7:0]  fetch_row;
  logic        engine_valid, gemm_finish, engine_ready;
  logic [2:0]  op_type;
  logic [7:0]  kernel, i_side, o_side, kernel_size, row_cnt;
  logic [3:0]  stride;
  logic [15:0] i_channel, o_channel, stride2;
  logic        layer_done, err_tmo;

  modport slave (
    input  cmd_valid, cmd_op, cmd_kernel, cmd_stride, cmd_i_side, cmd_o_side,
           cmd_i_channel, cmd_o_channel, fetch_done, gemm_finish, engine_ready,
    output cmd_ready, fetch_req, fetch_row, engine_valid, op_type, kernel, stride,
           i_side, o_side, i_channel, o_channel, kernel_size, stride2, row_cnt,
           layer_done, err_tmo
  );

  modport master (
    output cmd_valid, cmd_op, cmd_kernel, cmd_stride, cmd_i_side, cmd_o_side,
           cmd_i_channel, cmd_o_channel, fetch_done, gemm_finish, engine_ready,
    input  cmd_ready, fetch_req, fetch_row, engine_valid, op_type, kernel, stride,
           i_side, o_side, i_channel, o_channel, kernel_size, stride2, row_cnt,
           layer_done, err_tmo
  );
endinterface

// File: rtl/layer_sched_watchdog.sv
// Saturating RUN-time watchdog; tmo holds once the counter reaches all-ones.
module sched_watchdog #(
  parameter int TMO_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tmo
);
  logic [TMO_W-1:0] cnt;

  assign tmo = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && !tmo)  cnt <= cnt + TMO_W'(1);
  end
endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: latches a layer command, then loops fetch -> run per output
// row until o_side rows complete, the engine ends the layer, or the watchdog fires.
module layer_sched
  import layer_sched_pkg::*;
#(
  parameter int TMO_W = 24
) (
  input logic         clk,
  input logic         rst,
  layer_sched_if.slave bus
);
  logic [2:0] state;
  cfg_t       cfg;
  logic [7:0] kernel_size, row_cnt;
  logic [15:0] stride2;
  logic       err_tmo, row_end, tmo;

  // row_end marks the idle cycle after gemm_finish where the new row_cnt is judged
  sched_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk(clk), .rst(rst),
    .en (state == S_RUN && !row_end),
    .clr(state != S_RUN),
    .tmo(tmo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg         <= '0;
      kernel_size <= '0;
      stride2     <= '0;
      row_cnt     <= '0;
      err_tmo     <= 1'b0;
      row_end     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          cfg     <= '{op: bus.cmd_op, kernel: bus.cmd_kernel, stride: bus.cmd_stride,
                       i_side: bus.cmd_i_side, o_side: bus.cmd_o_side,
                       i_channel: bus.cmd_i_channel, o_channel: bus.cmd_o_channel};
          row_cnt <= '0;
          err_tmo <= 1'b0;
          state   <= S_CFG;
        end
        S_CFG: begin
          kernel_size <= cfg.kernel * cfg.kernel;
          stride2     <= 16'(cfg.kernel) * 16'(cfg.stride);
          // illegal or empty layers are consumed without touching the DMA
          state       <= (op_legal(cfg.op) && cfg.o_side != 8'd0) ? S_FETCH : S_DONE;
        end
        S_FETCH: state <= bus.fetch_done ? S_RUN : S_WAITF;
        S_WAITF: if (bus.fetch_done) state <= S_RUN;
        S_RUN: begin
          if (bus.engine_ready) begin
            row_cnt <= cfg.o_side;
            row_end <= 1'b0;
            state   <= S_DONE;
          end else if (row_end) begin
            row_end <= 1'b0;
            state   <= (row_cnt == cfg.o_side) ? S_DONE : S_FETCH;
          end else if (tmo) begin
            err_tmo <= 1'b1;
            state   <= S_DONE;
          end else if (bus.gemm_finish) begin
            row_cnt <= row_cnt + 8'd1;
            row_end <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = (state == S_IDLE);
  assign bus.fetch_req    = (state == S_FETCH);
  assign bus.fetch_row    = (state == S_FETCH) ? row_cnt * {4'd0, cfg.stride} : 8'd0;
  assign bus.engine_valid = (state == S_RUN) && !row_end && !tmo;
  assign bus.layer_done   = (state == S_DONE);
  assign bus.op_type      = cfg.op;
  assign bus.kernel       = cfg.kernel;
  assign bus.stride       = cfg.stride;
  assign bus.i_side       = cfg.i_side;
  assign bus.o_side       = cfg.o_side;
  assign bus.i_channel    = cfg.i_channel;
  assign bus.o_channel    = cfg.o_channel;
  assign bus.kernel_size  = kernel_size;
  assign bus.stride2      = stride2;
  assign bus.row_cnt      = row_cnt;
  assign bus.err_tmo      = err_tmo;
endmodule
